// File: rtl/mem_req_arb_pkg.sv
// ============================================================================
// Module : mem_req_arb_pkg
// Brief  : Shared types and helpers for the mem_req_arb memory-request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_req_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_req_arb_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority picker; first set request above ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int w_pos;

  // Walk from the farthest slot to the nearest so the nearest set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = (int'(ptr) + k) % NUM_REQ;
      if (|(req & (NUM_REQ'(1) << w_pos))) begin
        gnt = NUM_REQ'(1) << w_pos;
        idx = ID_W'(w_pos);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_arb.sv
// ============================================================================
// Module : mem_req_arb
// Brief  : Burst-locked round-robin arbiter onto one registered memory port.
//          Optional starvation aging enabled by defining MEM_REQ_ARB_AGE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_req_arb
  import mem_req_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int AGE_MAX = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic                       m_we,
  output logic                       m_last,
  output logic [$clog2(NUM_REQ)-1:0] m_id
);

  localparam int c_ID_W = id_width(NUM_REQ);

  if (NUM_REQ < 2 || AGE_MAX < 1) begin : g_param_check
    $error("mem_req_arb: NUM_REQ must be >= 2 and AGE_MAX >= 1");
  end

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_ID_W-1:0]   r_owner;
  logic [c_ID_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0]  w_rr_gnt;
  logic [c_ID_W-1:0]   w_rr_idx;
  logic                w_rr_any;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic [c_ID_W-1:0]   w_win_idx;
  logic                w_win_any;
  logic                w_space;
  logic                w_accept;
  logic                w_win_last;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_age_any;
  logic [c_ID_W-1:0]   w_age_idx;
  logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

  assign w_space = ~m_valid | m_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (c_ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_rr_gnt),
    .idx (w_rr_idx),
    .any (w_rr_any)
  );

`ifdef MEM_REQ_ARB_AGE_EN
  localparam int c_AGE_W = $clog2(AGE_MAX + 1);

  logic [NUM_REQ-1:0] w_age_hit;

  // The current owner is mid-burst, not starving, so its counter is frozen.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    logic [c_AGE_W-1:0] r_age;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_age <= '0;
      end else if (req_valid[g] && req_ready[g]) begin
        if (r_state == ARB_IDLE) begin
          r_age <= '0;
        end
      end else if (req_valid[g] &&
                   !(r_state == ARB_LOCKED && r_owner == c_ID_W'(g)) &&
                   r_age != c_AGE_W'(AGE_MAX)) begin
        r_age <= r_age + 1'b1;
      end
    end

    assign w_age_hit[g] = req_valid[g] && (r_age == c_AGE_W'(AGE_MAX));
  end

  always_comb begin
    w_age_idx = '0;
    w_age_any = |w_age_hit;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (|(w_age_hit & (NUM_REQ'(1) << k))) begin
        w_age_idx = c_ID_W'(k);
      end
    end
  end
`else
  assign w_age_any = 1'b0;
  assign w_age_idx = '0;
`endif

  // State register together with the owner/pointer it qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= c_ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && r_state == ARB_IDLE) begin
        r_owner <= w_win_idx;
        r_ptr   <= w_win_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:   if (w_accept && !w_win_last) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_accept && w_win_last)  w_state_nxt = ARB_IDLE;
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_win_onehot = '0;
    w_win_idx    = '0;
    w_win_any    = 1'b0;
    req_ready    = '0;
    if (r_state == ARB_LOCKED) begin
      w_win_idx    = r_owner;
      w_win_onehot = NUM_REQ'(1) << r_owner;
      w_win_any    = |(req_valid & w_win_onehot);
      req_ready    = w_win_onehot & {NUM_REQ{w_space}};
    end else begin
      if (w_age_any) begin
        w_win_idx    = w_age_idx;
        w_win_onehot = NUM_REQ'(1) << w_age_idx;
      end else begin
        w_win_idx    = w_rr_idx;
        w_win_onehot = w_rr_gnt;
      end
      w_win_any = w_rr_any;
      if (w_rr_any) begin
        req_ready = w_win_onehot & {NUM_REQ{w_space}};
      end
    end
    w_accept = w_win_any & w_space;
  end

  assign w_win_addr  = w_addr_arr[w_win_idx];
  assign w_win_wdata = w_wdata_arr[w_win_idx];
  assign w_win_last  = |(req_last & w_win_onehot);
  assign w_win_we    = |(req_we & w_win_onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_we    <= 1'b0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (w_accept) begin
      m_valid <= 1'b1;
      m_addr  <= w_win_addr;
      m_wdata <= w_win_wdata;
      m_we    <= w_win_we;
      m_last  <= w_win_last;
      m_id    <= w_win_idx;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_req_arb.md
# mem_req_arb

Multi-requester arbiter sharing one memory-request port (L1/shared-memory interface) among NUM_REQ warp/LSU requesters. Round-robin choice per burst; the grant stays locked to the winner until its `last` beat is accepted. Feeds a single registered output stage with valid/ready handshake. Sits between per-warp load/store queues and the cache request port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, write-data width
- AGE_MAX, 15, starvation threshold in cycles (used only with aging enabled)

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accepted
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_we  in  NUM_REQ  write enable per beat
- req_last  in  NUM_REQ  final beat of burst
- m_valid  out  1  output beat valid (registered)
- m_ready  in  1  downstream accept
- m_addr  out  ADDR_W  registered address
- m_wdata  out  DATA_W  registered write data
- m_we  out  1  registered write enable
- m_last  out  1  registered last flag
- m_id  out  $clog2(NUM_REQ)  source requester index

## Operation
- States: IDLE (no owner), LOCKED (owner holds port mid-burst).
- Output slot free: `space = ~m_valid | m_ready`.
- IDLE: winner = first valid requester scanning from ptr+1 upward, wrapping modulo NUM_REQ. req_ready[winner] = space; all others 0.
  - Accepted beat with last=1: stay IDLE, ptr ← winner.
  - Accepted beat with last=0: go LOCKED, owner ← winner, ptr ← winner.
- LOCKED: req_ready[owner] = space; all others 0. Accepted beat with last=1 → IDLE. Owner dropping valid mid-burst → port stalls; lock is held, no timeout.
- Accepted beat loads the output register: m_addr/m_wdata/m_we/m_last from source, m_id ← source index, m_valid ← 1. If not loading and m_ready=1, m_valid ← 0.
- No valid requesters in IDLE: nothing granted, ptr unchanged.
- Requester raises valid while another is LOCKED: waits, no beat loss.

## Timing
- Reset values: m_valid=0, m_addr=0, m_wdata=0, m_we=0, m_last=0, m_id=0, state=IDLE, ptr=NUM_REQ-1 (requester 0 first priority), req_ready=0 until a valid arrives.
- req_ready is combinational from req_valid, state, ptr, m_valid, m_ready. No combinational path from req_* to m_*.
- Latency: accepted beat appears on m_* the following cycle.
- Throughput: one beat per cycle with m_ready held high, including back-to-back single-beat bursts from different requesters (no bubble on re-arbitration).
- Simultaneous m_ready=1 and new accept: register reloads; m_valid stays 1.
- m_* held stable while m_valid=1 and m_ready=0.
- Reset mid-burst: lock released, output beat discarded, all values return to reset state.

## Configuration
- MEM_REQ_ARB_AGE_EN defined: per-requester wait counter, saturating at AGE_MAX. It increments each cycle the requester is valid and not accepted, and clears when that requester's first beat is accepted. In IDLE, if any counter equals AGE_MAX, the lowest-index such requester wins, overriding round-robin. ptr still updates to the winner.
- Undefined: no counters; pure round-robin as above.

## Structure
- Package mem_req_arb_pkg: state enum (ARB_IDLE, ARB_LOCKED), ID-width localparam helper.
- Sub-module rr_pick: combinational rotate-priority picker (req vector and ptr in; one-hot grant and index out). Instantiated once; the aging override is muxed after it.

## Test plan
- Reset, then req_valid=4'b1111 single-beat, m_ready=1 → m_id sequence 0,1,2,3,0 on consecutive cycles.
- Req1 starts a 4-beat burst; req2 valid from the 2nd beat → req2 gets ready only after req1's last beat; m_id=1,1,1,1,2.
- m_ready low 3 cycles with m_valid=1 → m_* stable, req_ready all 0; m_ready high → drains, next beat follows the next cycle.
- Reset asserted during burst beat 2 → m_valid=0, state IDLE; after release, req0 wins first.
- With MEM_REQ_ARB_AGE_EN and AGE_MAX=3: req0 issuing continuous 16-beat bursts, req3 valid → req3 granted at the first IDLE after its counter hits 3.
- req_valid=0 for 10 cycles → no grants, ptr unchanged; next single request from req2 accepted immediately.
